stack_sequencer: RTL and testbench

Sequences multi-byte stack transfers for the CPU control unit by driving the stack pointer's `sel`/`sp_load` controls and the 8-bit memory bus. It performs push, pull and load requests of up to three bytes, as used by PHA/PHP, PLA/PLP, JSR/RTS, BRK/RTI and TXS. All stack addresses are `{8'h01, sp}`. The pull result is reassembled into one word for the control unit.

---
 rtl/stack_sequencer.sv | 119 +++++++++++
 tb/tb_stack_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// stack_sequencer: sequences 1..3 byte stack push/pull transfers and SP loads on page 0x01
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_op/req_len/push_data/load_val : request, accepted only while ready
//   sp, mem_rdata : current stack pointer (pre-incremented while sp_sel=01), read data one cycle after mem_re
//   sp_sel/sp_load/sp_d : stack pointer controls (00 hold, 01 inc, 10 dec)
//   mem_addr/mem_we/mem_re/mem_wdata : memory bus, address {8'h01, sp} during transfers
//   ready/done/pull_data/ovf/unf : status, reassembled pull word and guard flags
// Optional: define STACK_SEQ_GUARD_EN to suppress pushes at sp=00 (sets ovf) and pulls
// from an empty stack at sp=FF (sets unf); otherwise ovf/unf are tied 0.
module stack_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_len,
  input  logic [23:0] push_data,
  input  logic [7:0]  load_val,
  input  logic [7:0]  sp,
  input  logic [7:0]  mem_rdata,
  output logic [1:0]  sp_sel,
  output logic        sp_load,
  output logic [7:0]  sp_d,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  mem_wdata,
  output logic        ready,
  output logic        done,
  output logic [23:0] pull_data,
  output logic        ovf,
  output logic        unf
);
  typedef enum logic [2:0] {IDLE, PUSH, PULL, WAIT, LOAD, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] len_q, idx, pos, rd_idx;
  logic [23:0] data_q;
  logic [7:0] load_q;
  logic accept, last, push_blk, pull_blk, rd_pend, rd_zero;
  assign accept = state == IDLE && req_valid;
  assign last = idx == len_q - 2'd1;
  // bytes leave highest-first, so the byte slot counts down from len-1
  assign pos = len_q - 2'd1 - idx;
`ifdef STACK_SEQ_GUARD_EN
  // sp_q tracks the pointer register itself: during pulls the sp input is already
  // pre-incremented, so the value sampled at the last edge is the current register
  logic [7:0] sp_q;
  logic ovf_q, unf_q;
  assign push_blk = state == PUSH && sp == 8'h00;
  assign pull_blk = state == PULL && sp_q == 8'hFF;
  assign ovf = ovf_q;
  assign unf = unf_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sp_q <= 8'h00;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q <= sp;
      ovf_q <= accept ? 1'b0 : ovf_q | push_blk;
      unf_q <= accept ? 1'b0 : unf_q | pull_blk;
    end
`else
  assign push_blk = 1'b0;
  assign pull_blk = 1'b0;
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) state_nx = (req_len == 2'd0 || req_op == 2'b11) ? DONE :
                                      req_op == 2'b00 ? PUSH : req_op == 2'b01 ? PULL : LOAD;
      PUSH: if (last) state_nx = DONE;
      PULL: if (last) state_nx = WAIT;
      WAIT: state_nx = DONE;
      LOAD: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign ready = state == IDLE;
  assign done = state == DONE;
  assign mem_we = state == PUSH && !push_blk;
  assign mem_re = state == PULL && !pull_blk;
  assign mem_addr = (state == PUSH || state == PULL) ? {8'h01, sp} : 16'h0000;
  assign mem_wdata = state == PUSH ? 8'(data_q >> {pos, 3'b000}) : 8'h00;
  assign sp_sel = mem_we ? 2'b10 : mem_re ? 2'b01 : 2'b00;
  assign sp_load = state == LOAD;
  assign sp_d = sp_load ? load_q : 8'h00;
  // read data trails mem_re by one cycle; rd_* remember which slot it belongs to
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      len_q <= 2'd0;
      idx <= 2'd0;
      data_q <= 24'h0;
      load_q <= 8'h00;
      rd_pend <= 1'b0;
      rd_zero <= 1'b0;
      rd_idx <= 2'd0;
      pull_data <= 24'h0;
    end else begin
      state <= state_nx;
      rd_pend <= state == PULL;
      rd_zero <= pull_blk;
      rd_idx <= idx;
      if (accept) begin
        len_q <= req_len;
        idx <= 2'd0;
        data_q <= push_data;
        load_q <= load_val;
        pull_data <= 24'h0;
      end else begin
        if (state == PUSH || state == PULL) idx <= idx + 2'd1;
        if (rd_pend) pull_data <= pull_data | (24'(rd_zero ? 8'h00 : mem_rdata) << {rd_idx, 3'b000});
      end
    end
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: self-checking bench with a stack memory, an external SP model and a request-level reference model
module tb_stack_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic [1:0] req_op = 2'd0, req_len = 2'd0;
  logic [23:0] push_data = 24'h0;
  logic [7:0] load_val = 8'h00, sp, mem_rdata = 8'h00;
  logic [1:0] sp_sel;
  logic sp_load, mem_we, mem_re, ready, done, ovf, unf;
  logic [7:0] sp_d, mem_wdata;
  logic [15:0] mem_addr;
  logic [23:0] pull_data;

  stack_sequencer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_len(req_len),
    .push_data(push_data), .load_val(load_val), .sp(sp), .mem_rdata(mem_rdata),
    .sp_sel(sp_sel), .sp_load(sp_load), .sp_d(sp_d), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_re(mem_re), .mem_wdata(mem_wdata), .ready(ready), .done(done), .pull_data(pull_data),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // environment: page-1 memory with one-cycle read latency, and an SP register
  // that saturates at 00 on decrement and shows its incremented value while sp_sel=01
  logic [7:0] mem [256];
  logic [7:0] sp_reg = 8'h00;
  assign sp = (sp_sel == 2'b01) ? sp_reg + 8'd1 : sp_reg;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= mem_re ? mem[mem_addr[7:0]] : 8'($urandom);
    if (sp_load) sp_reg <= sp_d;
    else if (sp_sel == 2'b01) sp_reg <= sp_reg + 8'd1;
    else if (sp_sel == 2'b10 && sp_reg != 8'h00) sp_reg <= sp_reg - 8'd1;
  end

  int checks = 0, failures = 0;
  logic [7:0] m_sp;
  int lat, ld_n;
  logic acc_rdy, rdy_after, ov, un;
  logic [15:0] wr_a[$], rd_a[$];
  logic [7:0] wr_d[$];
  logic [1:0] sel_q[$];
  logic [7:0] ld_v;
  logic [23:0] pd, pd_after;

  // drives one request (called in the low clock phase) and records what the DUT did
  task automatic xfer(input logic [1:0] op, input logic [1:0] len, input logic [23:0] d,
                      input logic [7:0] lv, input bit hold);
    wr_a.delete(); wr_d.delete(); rd_a.delete(); sel_q.delete();
    lat = 0; ld_n = 0; ld_v = 8'h00; pd = 24'h0; ov = 1'b0; un = 1'b0;
    req_op = op; req_len = len; push_data = d; load_val = lv; req_valid = 1'b1;
    acc_rdy = ready;
    @(posedge clk); #1;
    req_valid = hold;
    req_op = 2'($urandom); req_len = 2'($urandom); push_data = 24'($urandom); load_val = 8'($urandom);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (mem_we) begin wr_a.push_back(mem_addr); wr_d.push_back(mem_wdata); end
      if (mem_re) rd_a.push_back(mem_addr);
      if (sp_sel != 2'b00) sel_q.push_back(sp_sel);
      if (sp_load) begin ld_n++; ld_v = sp_d; end
      if (done) begin lat = c; pd = pull_data; ov = ovf; un = unf; break; end
    end
    req_valid = 1'b0;
    @(negedge clk);
    rdy_after = ready;
    pd_after = pull_data;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({ready, done, mem_we, mem_re, sp_load, sp_sel, mem_addr, mem_wdata, sp_d, pull_data, ovf, unf} !== {1'b1, 64'd0}) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", {ready, done, mem_we, mem_re, sp_load, sp_sel, mem_addr, mem_wdata, sp_d, pull_data, ovf, unf}, {1'b1, 64'd0});
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL after_reset got ready=%b done=%b exp ready=1 done=0", ready, done); end
  endtask

  task automatic test_load;
    xfer(2'b10, 2'd1, 24'h0, 8'h80, 1'b0);
    checks++; if (lat != 2) begin failures++; $display("FAIL load_lat got=%0d exp=2", lat); end
    checks++; if (ld_n != 1 || ld_v !== 8'h80) begin failures++; $display("FAIL load_strobe got n=%0d sp_d=%h exp n=1 sp_d=80", ld_n, ld_v); end
    checks++; if (wr_a.size() + rd_a.size() != 0) begin failures++; $display("FAIL load_bus got strobes=%0d exp=0", wr_a.size() + rd_a.size()); end
    checks++; if (sp_reg !== 8'h80) begin failures++; $display("FAIL load_sp got=%h exp=80", sp_reg); end
    xfer(2'b10, 2'd1, 24'h0, 8'hFD, 1'b0);
    m_sp = 8'hFD;
  endtask

  task automatic test_push;
    xfer(2'b00, 2'd3, 24'h123456, 8'h00, 1'b0);
    checks++; if (lat != 4) begin failures++; $display("FAIL push_lat got=%0d exp=4", lat); end
    checks++;
    if (wr_a.size() != 3 || {wr_a[0], wr_a[1], wr_a[2]} !== 48'h01FD_01FC_01FB || {wr_d[0], wr_d[1], wr_d[2]} !== 24'h123456) begin
      failures++; $display("FAIL push_writes got n=%0d first_addr=%h first_data=%h exp 01FD/01FC/01FB 12/34/56", wr_a.size(), wr_a[0], wr_d[0]);
    end
    checks++; if (sel_q.size() != 3 || {sel_q[0], sel_q[1], sel_q[2]} !== 6'b101010) begin failures++; $display("FAIL push_sel got n=%0d exp 3 x 10", sel_q.size()); end
    checks++; if (sp_reg !== 8'hFA) begin failures++; $display("FAIL push_sp got=%h exp=FA", sp_reg); end
    m_sp = 8'hFA;
  endtask

  task automatic test_pull;
    xfer(2'b01, 2'd2, 24'h0, 8'h00, 1'b1);
    checks++; if (lat != 4) begin failures++; $display("FAIL pull_lat got=%0d exp=4", lat); end
    checks++; if (rd_a.size() != 2 || {rd_a[0], rd_a[1]} !== 32'h01FB_01FC) begin failures++; $display("FAIL pull_addr got n=%0d first=%h exp 01FB,01FC", rd_a.size(), rd_a[0]); end
    checks++; if (pd !== 24'h003456) begin failures++; $display("FAIL pull_data got=%h exp=003456", pd); end
    checks++; if (sp_reg !== 8'hFC || rdy_after !== 1'b1) begin failures++; $display("FAIL pull_busy_ignore got sp=%h ready=%b exp sp=FC ready=1", sp_reg, rdy_after); end
    m_sp = 8'hFC;
  endtask

  task automatic test_zero_len;
    xfer(2'b00, 2'd0, 24'hFFFFFF, 8'h00, 1'b0);
    checks++; if (lat != 1 || wr_a.size() != 0 || sel_q.size() != 0) begin failures++; $display("FAIL zero_len got lat=%0d writes=%0d exp lat=1 writes=0", lat, wr_a.size()); end
    xfer(2'b11, 2'd3, 24'hFFFFFF, 8'h11, 1'b0);
    checks++; if (lat != 1 || wr_a.size() + rd_a.size() + ld_n != 0 || sp_reg !== m_sp) begin failures++; $display("FAIL reserved_op got lat=%0d sp=%h exp lat=1 sp=%h", lat, sp_reg, m_sp); end
  endtask

  task automatic test_back_to_back;
    xfer(2'b00, 2'd1, 24'h000077, 8'h00, 1'b0);
    checks++; if (lat != 2 || wr_a.size() != 1 || wr_a[0] !== 16'h01FC) begin failures++; $display("FAIL b2b_push got lat=%0d addr=%h exp lat=2 addr=01FC", lat, wr_a[0]); end
    xfer(2'b01, 2'd1, 24'h0, 8'h00, 1'b0);
    checks++; if (acc_rdy !== 1'b1 || lat != 3 || pd !== 24'h000077) begin failures++; $display("FAIL b2b_pull got ready=%b lat=%0d data=%h exp ready=1 lat=3 data=000077", acc_rdy, lat, pd); end
    xfer(2'b10, 2'd2, 24'h0, 8'hC0, 1'b0);
    checks++; if (acc_rdy !== 1'b1 || lat != 2 || sp_reg !== 8'hC0) begin failures++; $display("FAIL b2b_load got ready=%b lat=%0d sp=%h exp ready=1 lat=2 sp=C0", acc_rdy, lat, sp_reg); end
    m_sp = 8'hC0;
  endtask

  task automatic test_guard;
    xfer(2'b10, 2'd1, 24'h0, 8'h00, 1'b0);
    xfer(2'b00, 2'd2, 24'h00BEEF, 8'h00, 1'b0);
    checks++; if (lat != 3) begin failures++; $display("FAIL guard_push_lat got=%0d exp=3", lat); end
`ifdef STACK_SEQ_GUARD_EN
    checks++; if (wr_a.size() != 0 || sel_q.size() != 0 || ov !== 1'b1) begin failures++; $display("FAIL guard_push got writes=%0d sels=%0d ovf=%b exp 0 0 1", wr_a.size(), sel_q.size(), ov); end
`else
    checks++;
    if (wr_a.size() != 2 || {wr_a[0], wr_a[1]} !== 32'h0100_0100 || {wr_d[0], wr_d[1]} !== 16'hBEEF || ov !== 1'b0) begin
      failures++; $display("FAIL guard_push got writes=%0d addr=%h ovf=%b exp 2 writes at 0100 BE,EF ovf=0", wr_a.size(), wr_a[0], ov);
    end
`endif
    checks++; if (sp_reg !== 8'h00) begin failures++; $display("FAIL guard_push_sp got=%h exp=00", sp_reg); end
    xfer(2'b10, 2'd1, 24'h0, 8'hFF, 1'b0);
    xfer(2'b01, 2'd1, 24'h0, 8'h00, 1'b0);
`ifdef STACK_SEQ_GUARD_EN
    checks++; if (rd_a.size() != 0 || pd !== 24'h0 || un !== 1'b1 || sp_reg !== 8'hFF) begin failures++; $display("FAIL guard_pull got reads=%0d data=%h unf=%b sp=%h exp 0 000000 1 FF", rd_a.size(), pd, un, sp_reg); end
    m_sp = 8'hFF;
`else
    checks++; if (rd_a.size() != 1 || rd_a[0] !== 16'h0100 || pd !== 24'h0000EF || un !== 1'b0 || sp_reg !== 8'h00) begin failures++; $display("FAIL guard_pull got reads=%0d data=%h unf=%b sp=%h exp 1 0000EF 0 00", rd_a.size(), pd, un, sp_reg); end
    m_sp = 8'h00;
`endif
    checks++; if (pd_after !== pd) begin failures++; $display("FAIL guard_hold got=%h exp=%h", pd_after, pd); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] pre;
    int nw, nd;
    xfer(2'b10, 2'd1, 24'h0, 8'hFD, 1'b0);
    pre = mem[8'hFB];
    req_op = 2'b00; req_len = 2'd3; push_data = 24'hAABBCC; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h01FD || mem_wdata !== 8'hAA) begin failures++; $display("FAIL rst_mid_first got we=%b addr=%h data=%h exp 1 01FD AA", mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({ready, done, mem_we, mem_re, sp_load, sp_sel, mem_addr, mem_wdata, sp_d, pull_data, ovf, unf} !== {1'b1, 64'd0}) begin
      failures++; $display("FAIL rst_mid_outputs got=%h exp=%h", {ready, done, mem_we, mem_re, sp_load, sp_sel, mem_addr, mem_wdata, sp_d, pull_data, ovf, unf}, {1'b1, 64'd0});
    end
    @(negedge clk); reset = 1'b1;
    nw = 0; nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      nw += int'(mem_we);
      nd += int'(done);
    end
    checks++; if (nw != 0 || nd != 0) begin failures++; $display("FAIL rst_mid_abandon got writes=%0d dones=%0d exp 0 0", nw, nd); end
    checks++; if (mem[8'hFB] !== pre || sp_reg !== 8'hFC) begin failures++; $display("FAIL rst_mid_state got mem=%h sp=%h exp mem=%h sp=FC", mem[8'hFB], sp_reg, pre); end
    m_sp = 8'hFC;
  endtask

  // reference model works per request: expected bus trace, latency, result word and final SP
  task automatic test_random;
    for (int it = 0; it < 40; it++) begin
      logic [1:0] op, len;
      logic [23:0] d, exp_pd;
      logic [7:0] lv, exp_sp;
      int exp_lat, nw, nr;
      op = 2'($urandom); len = 2'($urandom); d = 24'($urandom); lv = 8'($urandom_range(8, 247));
      if ((op == 2'b00 && m_sp < 8'd3) || (op == 2'b01 && m_sp > 8'hFC)) op = 2'b10;
      nw = (op == 2'b00) ? int'(len) : 0;
      nr = (op == 2'b01) ? int'(len) : 0;
      exp_lat = (len == 2'd0 || op == 2'b11) ? 1 : op == 2'b00 ? int'(len) + 1 : op == 2'b01 ? int'(len) + 2 : 2;
      exp_sp = (len == 2'd0 || op == 2'b11) ? m_sp : op == 2'b00 ? m_sp - 8'(len) : op == 2'b01 ? m_sp + 8'(len) : lv;
      exp_pd = 24'h0;
      for (int k = 0; k < nr; k++) exp_pd = exp_pd + (24'(mem[m_sp + 8'(k + 1)]) << (8 * k));
      xfer(op, len, d, lv, it[0]);
      checks++; if (lat != exp_lat || acc_rdy !== 1'b1 || rdy_after !== 1'b1) begin failures++; $display("FAIL rnd%0d_timing got lat=%0d ready=%b/%b exp lat=%0d ready=1/1", it, lat, acc_rdy, rdy_after, exp_lat); end
      checks++; if (wr_a.size() != nw || rd_a.size() != nr || sel_q.size() != nw + nr) begin failures++; $display("FAIL rnd%0d_counts got w=%0d r=%0d s=%0d exp w=%0d r=%0d s=%0d", it, wr_a.size(), rd_a.size(), sel_q.size(), nw, nr, nw + nr); end
      for (int k = 0; k < nw && k < wr_a.size(); k++) begin
        checks++;
        if (wr_a[k] !== {8'h01, m_sp - 8'(k)} || wr_d[k] !== 8'(d >> (8 * (int'(len) - 1 - k))) || sel_q[k] !== 2'b10) begin
          failures++; $display("FAIL rnd%0d_write%0d got addr=%h data=%h exp addr=%h data=%h", it, k, wr_a[k], wr_d[k], {8'h01, m_sp - 8'(k)}, 8'(d >> (8 * (int'(len) - 1 - k))));
        end
      end
      for (int k = 0; k < nr && k < rd_a.size(); k++) begin
        checks++;
        if (rd_a[k] !== {8'h01, m_sp + 8'(k + 1)} || sel_q[k] !== 2'b01) begin failures++; $display("FAIL rnd%0d_read%0d got addr=%h exp addr=%h", it, k, rd_a[k], {8'h01, m_sp + 8'(k + 1)}); end
      end
      checks++; if (pd !== exp_pd || pd_after !== exp_pd || ov !== 1'b0 || un !== 1'b0) begin failures++; $display("FAIL rnd%0d_result got data=%h held=%h ovf=%b unf=%b exp data=%h flags=0", it, pd, pd_after, ov, un, exp_pd); end
      checks++; if (ld_n != ((op == 2'b10 && len != 2'd0) ? 1 : 0) || sp_reg !== exp_sp) begin failures++; $display("FAIL rnd%0d_sp got loads=%0d sp=%h exp sp=%h", it, ld_n, sp_reg, exp_sp); end
      m_sp = exp_sp;
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_push;
    test_pull;
    test_zero_len;
    test_back_to_back;
    test_guard;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule
